blob_stream_tx: RTL and testbench
=================================

// Module: blob_stream_tx
// PURPOSE
//  Transmitter end of the layer blob stream (rdy/en/eop/64-bit data). On start, reads one
//  complete blob (BEATS words) from a synchronous feature-map RAM. Presents the words to
//  the downstream layer's blob_din port, e.g. pool2 input: 16x16x32 bytes = 1024 beats.
//  A credit-controlled skid FIFO absorbs RAM read latency, giving 1 beat/cycle under rdy.
// PARAMETERS
//  DW          64    data width of RAM word and blob beat
//  BEATS       1024  beats per blob (>=1); last beat carries eop
//  ADDR_W      10    RAM address width; addresses wrap mod 2**ADDR_W
//  RD_LATENCY  2     cycles from mem_rd_en to mem_rd_data valid (>=1)
//  FIFO_DEPTH  4     skid FIFO entries; must be >= RD_LATENCY+1 for full throughput
// PORTS
//  clk            in   1       clock
//  rst            in   1       synchronous active-high reset
//  start          in   1       pulse: begin transmitting one blob
//  base_addr      in   ADDR_W  RAM address of beat 0, sampled with accepted start
//  busy           out  1       blob in progress
//  done           out  1       one-cycle pulse after eop beat transferred
//  mem_rd_en      out  1       RAM read strobe
//  mem_rd_addr    out  ADDR_W  RAM read address
//  mem_rd_data    in   DW      RAM read data, valid RD_LATENCY cycles after mem_rd_en
//  blob_dout_rdy  in   1       downstream can accept a beat this cycle
//  blob_dout_en   out  1       beat transferred this cycle
//  blob_dout_eop  out  1       this beat is the last of the blob
//  blob_dout      out  DW      beat data
// BEHAVIOUR
//  Reset: all outputs 0; FIFO emptied, counters 0, read-valid pipe cleared, state IDLE.
//   Reset mid-blob aborts without eop or done; RAM data returning afterwards is dropped.
//  FSM: IDLE --start--> RUN --last read issued--> DRAIN --eop beat sent--> DONE --> IDLE.
//   start accepted only in IDLE; ignored in RUN/DRAIN/DONE. busy=1 in RUN/DRAIN.
//   done=1 only in DONE (one cycle). busy=0 in IDLE/DONE.
//  Read issue (RUN): mem_rd_en=1 when rd_cnt<BEATS and inflight+fifo_cnt-pop < FIFO_DEPTH.
//   pop = beat transferred in the same cycle.
//   mem_rd_addr = base_addr+rd_cnt (mod 2**ADDR_W); rd_cnt increments per read.
//   A RD_LATENCY-deep valid shift register tracks inflight reads.
//   Its output writes mem_rd_data into the FIFO. The credit rule guarantees no overflow.
//  Transfer: blob_dout_en = blob_dout_rdy & FIFO non-empty & (RUN|DRAIN).
//   This is a combinational rdy->en path; the sink samples rdy/en in the same cycle.
//   blob_dout = FIFO head when en=1, else 0.
//   blob_dout_eop = en & (tx_cnt==BEATS-1); tx_cnt counts transferred beats.
//   Simultaneous FIFO push and pop in one cycle are both honoured.
//  Latency: start sampled at cycle T -> first mem_rd_en at T+1.
//   First blob_dout_en at T+RD_LATENCY+2 if rdy is held high.
//   Last beat at T+RD_LATENCY+BEATS+1; done at T+RD_LATENCY+BEATS+2.
//  Backpressure: rdy=0 stalls transfers; reads continue until credits are exhausted,
//   then stop. No beat is lost or duplicated, and order is preserved.
//  BEATS=1: the single beat carries eop; RUN goes directly to DRAIN after one read.
//  start in the DONE cycle is ignored; start in the next cycle (IDLE) is accepted.
// TESTING
//  1 rdy=1, base=0, RAM[i]=i, BEATS=1024 -> first en at T+4.
//    1024 consecutive beats with data i; eop only on beat 1023; done at T+1028.
//  2 rdy toggles 1010..., then random 30% low -> data sequence intact.
//    No FIFO overflow (assert fifo_cnt<=4); en never high while rdy=0.
//  3 base_addr=1020 -> addresses wrap 1020..1023,0..1019; data matches RAM order.
//  4 start pulsed in RUN and in DONE -> ignored; exactly one blob sent.
//    A start one cycle after done -> second blob sent, identical to the first.
//  5 rst asserted at beat 500 -> next cycle all outputs 0, no eop/done.
//    Late RAM returns dropped; new start sends a full 1024-beat blob.
//  6 BEATS=1, RD_LATENCY=1, FIFO_DEPTH=2 -> one beat with en & eop at T+3; done at T+4.

Source files
------------

// File: rtl/blob_stream_tx.sv
// Blob stream transmitter: reads one blob from a synchronous feature-map RAM and
// streams it downstream, using a credit-controlled skid FIFO to hide read latency.
module blob_stream_tx #(
   parameter int unsigned DW         = 64,
   parameter int unsigned BEATS      = 1024,
   parameter int unsigned ADDR_W     = 10,
   parameter int unsigned RD_LATENCY = 2,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              busy,
   output logic              done,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [DW-1:0]     mem_rd_data,
   input  logic              blob_dout_rdy,
   output logic              blob_dout_en,
   output logic              blob_dout_eop,
   output logic [DW-1:0]     blob_dout
);

   localparam int unsigned CNT_W = $clog2(BEATS + 1);
   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned FC_W  = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned IF_W  = $clog2(RD_LATENCY + 1);
   localparam int unsigned CR_W  = $clog2(FIFO_DEPTH + RD_LATENCY + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                state, state_nxt;
   logic [ADDR_W-1:0]     base_q;
   logic [CNT_W-1:0]      rd_cnt, tx_cnt;
   logic [RD_LATENCY-1:0] vld_pipe;
   logic [IF_W-1:0]       inflight;
   logic [DW-1:0]         fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [FC_W-1:0]       fifo_cnt;
   logic [CR_W-1:0]       credit_used;
   logic                  start_acc, rd_fire, push, pop, last_tx;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign push        = vld_pipe[RD_LATENCY-1];
   assign start_acc   = (state == S_IDLE) && start;
   assign last_tx     = (tx_cnt == CNT_W'(BEATS - 1));
   // A pop this cycle frees a slot that the read issued now may rely on.
   assign credit_used = CR_W'(inflight) + CR_W'(fifo_cnt) - CR_W'(pop);

   // Next-state and output decode
   always_comb begin
      state_nxt     = state;
      busy          = 1'b0;
      done          = 1'b0;
      rd_fire       = 1'b0;
      pop           = 1'b0;
      mem_rd_en     = 1'b0;
      mem_rd_addr   = '0;
      blob_dout_en  = 1'b0;
      blob_dout_eop = 1'b0;
      blob_dout     = '0;

      if ((state == S_RUN || state == S_DRAIN) && blob_dout_rdy && (fifo_cnt != '0))
         pop = 1'b1;

      case (state)
         S_IDLE: begin
            if (start)
               state_nxt = S_RUN;
         end
         S_RUN: begin
            busy    = 1'b1;
            rd_fire = (rd_cnt < CNT_W'(BEATS)) && (credit_used < CR_W'(FIFO_DEPTH));
            if (rd_fire && (rd_cnt == CNT_W'(BEATS - 1)))
               state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            busy = 1'b1;
            if (pop && last_tx)
               state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase

      mem_rd_en = rd_fire;
      if (rd_fire)
         mem_rd_addr = base_q + ADDR_W'(rd_cnt);
      blob_dout_en  = pop;
      blob_dout_eop = pop && last_tx;
      if (pop)
         blob_dout = fifo_mem[rd_ptr];
   end

   // State, counters, read-valid pipe and FIFO bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         base_q   <= '0;
         rd_cnt   <= '0;
         tx_cnt   <= '0;
         vld_pipe <= '0;
         inflight <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         state    <= state_nxt;
         vld_pipe <= RD_LATENCY'({vld_pipe, rd_fire});
         inflight <= inflight + IF_W'(rd_fire) - IF_W'(push);
         fifo_cnt <= fifo_cnt + FC_W'(push) - FC_W'(pop);
         if (push)
            wr_ptr <= ptr_inc(wr_ptr);
         if (pop)
            rd_ptr <= ptr_inc(rd_ptr);
         if (start_acc) begin
            base_q <= base_addr;
            rd_cnt <= '0;
            tx_cnt <= '0;
         end else begin
            if (rd_fire)
               rd_cnt <= rd_cnt + 1'b1;
            if (pop)
               tx_cnt <= tx_cnt + 1'b1;
         end
      end
   end

   // Skid FIFO storage; contents are don't-care until pushed
   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr] <= mem_rd_data;
   end

endmodule

// File: tb/tb_blob_stream_tx.sv
// Directed bench for blob_stream_tx: full 1024-beat blobs with backpressure, wrap,
// start filtering, mid-blob reset, plus a single-beat configuration.
module tb_blob_stream_tx;

   localparam int unsigned DW = 64;
   localparam int unsigned AW = 10;
   localparam int NB = 1024;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // main instance
   logic          start, busy, done, mem_rd_en, rdy, en, eop;
   logic [AW-1:0] base_addr, mem_rd_addr;
   logic [DW-1:0] mem_rd_data, dout;
   logic [DW-1:0] ram_s1, ram_s2;

   // single-beat instance
   logic          s_start, s_busy, s_done, s_rd_en, s_rdy, s_en, s_eop;
   logic [AW-1:0] s_base, s_addr;
   logic [DW-1:0] s_rd_data, s_dout, s_ram;

   blob_stream_tx #(.DW(DW), .BEATS(NB), .ADDR_W(AW), .RD_LATENCY(2), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .busy(busy), .done(done),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
      .blob_dout_rdy(rdy), .blob_dout_en(en), .blob_dout_eop(eop), .blob_dout(dout));

   blob_stream_tx #(.DW(DW), .BEATS(1), .ADDR_W(AW), .RD_LATENCY(1), .FIFO_DEPTH(2)) u_small (
      .clk(clk), .rst(rst), .start(s_start), .base_addr(s_base), .busy(s_busy), .done(s_done),
      .mem_rd_en(s_rd_en), .mem_rd_addr(s_addr), .mem_rd_data(s_rd_data),
      .blob_dout_rdy(s_rdy), .blob_dout_en(s_en), .blob_dout_eop(s_eop), .blob_dout(s_dout));

   // RAM models: RAM[i] = i, garbage on cycles without a read
   always @(posedge clk) begin
      ram_s1 <= mem_rd_en ? 64'(mem_rd_addr) : 64'hDEAD_BEEF_DEAD_BEEF;
      ram_s2 <= ram_s1;
      s_ram  <= s_rd_en ? (64'hA5A5_0000_0000_0000 | 64'(s_addr)) : 64'hDEAD_BEEF_DEAD_BEEF;
   end
   assign mem_rd_data = ram_s2;
   assign s_rd_data   = s_ram;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // monitor state
   logic [DW-1:0] beat_q[$];
   bit            eop_q[$];
   int            addr_q[$];
   int            first_en, first_rd, done_cyc, done_cnt, rdy_viol, eop_viol, ovf;

   task automatic clear_mon();
      beat_q.delete();
      eop_q.delete();
      addr_q.delete();
      first_en = -1;
      first_rd = -1;
      done_cyc = -1;
      done_cnt = 0;
      rdy_viol = 0;
      eop_viol = 0;
      ovf      = 0;
   endtask

   always @(negedge clk) begin
      if (mem_rd_en) begin
         addr_q.push_back(int'(mem_rd_addr));
         if (first_rd < 0) first_rd = cyc;
      end
      if (en) begin
         beat_q.push_back(dout);
         eop_q.push_back(eop);
         if (first_en < 0) first_en = cyc;
      end
      if (en && !rdy) rdy_viol++;
      if (eop && !en) eop_viol++;
      if (dut.fifo_cnt > 3'd4) ovf++;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   // rdy driver: 0 = always high, 1 = toggle until toggle_until then ~30% low
   int rdy_mode = 0;
   int toggle_until = 0;
   initial begin
      rdy = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode == 0) rdy = 1'b1;
         else if (cyc < toggle_until) rdy = ~rdy;
         else rdy = ($urandom_range(0, 9) >= 3);
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   int t_start;

   task automatic start_blob(input logic [AW-1:0] base);
      start     = 1'b1;
      base_addr = base;
      t_start   = cyc;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin
         step();
         n++;
      end
      if (done_cnt == 0) chk({tag, "_timeout"}, 64'd0, 64'd1);
      step();
      step();
   endtask

   task automatic check_blob(input string tag, input int base);
      int derr = 0;
      int ecnt = 0;
      int epos = -1;
      chk({tag, "_beats"}, 64'(beat_q.size()), 64'(NB));
      foreach (beat_q[k]) begin
         if (beat_q[k] !== 64'((base + k) % NB)) derr++;
         if (eop_q[k]) begin
            ecnt++;
            epos = k;
         end
      end
      chk({tag, "_data_err"}, 64'(derr), 64'd0);
      chk({tag, "_eop_cnt"}, 64'(ecnt), 64'd1);
      chk({tag, "_eop_pos"}, 64'(epos), 64'(NB - 1));
      chk({tag, "_eop_noen"}, 64'(eop_viol), 64'd0);
   endtask

   initial begin
      int n, nb, aerr, ecnt;
      int s_en_n, s_en_cyc, s_done_n, s_done_cyc;
      logic [DW-1:0] s_data;
      logic s_eopv;

      start = 1'b0; base_addr = '0;
      s_start = 1'b0; s_base = 10'd5; s_rdy = 1'b1;
      clear_mon();
      repeat (3) step();
      rst = 1'b0;
      step();
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_en", 64'(en), 64'd0);
      chk("rst_rd_en", 64'(mem_rd_en), 64'd0);

      // 1: full throughput, exact latencies
      clear_mon();
      start_blob(10'd0);
      wait_done(3000, "t1");
      check_blob("t1", 0);
      chk("t1_first_rd", 64'(first_rd - t_start), 64'd1);
      chk("t1_first_en", 64'(first_en - t_start), 64'd4);
      chk("t1_done_at", 64'(done_cyc - t_start), 64'd1028);
      chk("t1_done_cnt", 64'(done_cnt), 64'd1);
      chk("t1_busy_end", 64'(busy), 64'd0);

      // 2: backpressure, toggle then random
      clear_mon();
      rdy_mode = 1;
      toggle_until = cyc + 200;
      start_blob(10'd0);
      wait_done(10000, "t2");
      rdy_mode = 0;
      step();
      check_blob("t2", 0);
      chk("t2_en_wo_rdy", 64'(rdy_viol), 64'd0);
      chk("t2_fifo_ovf", 64'(ovf), 64'd0);

      // 3: address wrap
      clear_mon();
      start_blob(10'd1020);
      wait_done(3000, "t3");
      check_blob("t3", 1020);
      aerr = 0;
      foreach (addr_q[k]) if (addr_q[k] != (1020 + k) % NB) aerr++;
      chk("t3_rd_count", 64'(addr_q.size()), 64'(NB));
      chk("t3_addr_err", 64'(aerr), 64'd0);

      // 4: start ignored in RUN and DONE, accepted in the following IDLE
      clear_mon();
      start_blob(10'd0);
      repeat (8) step();
      start = 1'b1;
      step();
      start = 1'b0;
      n = 0;
      while (!done && n < 3000) begin
         step();
         n++;
      end
      if (!done) chk("t4_done_timeout", 64'd0, 64'd1);
      start = 1'b1;
      step();
      chk("t4_done_start_ign", 64'(busy), 64'd0);
      check_blob("t4a", 0);
      chk("t4a_done_cnt", 64'(done_cnt), 64'd1);
      clear_mon();
      t_start = cyc;
      step();
      start = 1'b0;
      chk("t4_idle_start", 64'(busy), 64'd1);
      wait_done(3000, "t4b");
      check_blob("t4b", 0);
      chk("t4b_first_en", 64'(first_en - t_start), 64'd4);

      // 5: reset at beat 500
      clear_mon();
      start_blob(10'd0);
      n = 0;
      while (beat_q.size() < 500 && n < 3000) begin
         step();
         n++;
      end
      chk("t5_reach500", 64'(beat_q.size()), 64'd500);
      rst = 1'b1;
      step();
      chk("t5_busy", 64'(busy), 64'd0);
      chk("t5_done", 64'(done), 64'd0);
      chk("t5_en", 64'(en), 64'd0);
      chk("t5_eop", 64'(eop), 64'd0);
      chk("t5_rd_en", 64'(mem_rd_en), 64'd0);
      chk("t5_rd_addr", 64'(mem_rd_addr), 64'd0);
      chk("t5_dout", dout, 64'd0);
      rst = 1'b0;
      nb = beat_q.size();
      repeat (10) step();
      ecnt = 0;
      foreach (eop_q[k]) if (eop_q[k]) ecnt++;
      chk("t5_no_late_beats", 64'(beat_q.size()), 64'(nb));
      chk("t5_no_eop", 64'(ecnt), 64'd0);
      chk("t5_no_done", 64'(done_cnt), 64'd0);
      clear_mon();
      start_blob(10'd0);
      wait_done(3000, "t5b");
      check_blob("t5b", 0);

      // 6: BEATS=1, RD_LATENCY=1, FIFO_DEPTH=2
      s_en_n = 0; s_en_cyc = -1; s_done_n = 0; s_done_cyc = -1;
      s_data = '0; s_eopv = 1'b0;
      s_start = 1'b1;
      t_start = cyc;
      step();
      s_start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (s_en) begin
            s_en_n++;
            s_en_cyc = cyc;
            s_data = s_dout;
            s_eopv = s_eop;
         end
         if (s_done) begin
            s_done_n++;
            s_done_cyc = cyc;
         end
         step();
      end
      chk("t6_en_cnt", 64'(s_en_n), 64'd1);
      chk("t6_en_at", 64'(s_en_cyc - t_start), 64'd3);
      chk("t6_data", s_data, 64'hA5A5_0000_0000_0005);
      chk("t6_eop", 64'(s_eopv), 64'd1);
      chk("t6_done_cnt", 64'(s_done_n), 64'd1);
      chk("t6_done_at", 64'(s_done_cyc - t_start), 64'd4);
      chk("t6_busy_end", 64'(s_busy), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
